// File: rtl/spi_master.sv
// Memory-mapped SPI master: TX/RX byte FIFOs behind a two-register CPU port,
// a four-state shifter driving sck/mosi and sampling miso in all four SPI modes.

module spi_master_fifo #(
  parameter int BITS = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  logic [7:0]  mem [2**BITS];
  logic [BITS:0] wptr;
  logic [BITS:0] rptr;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[BITS] != rptr[BITS]) && (wptr[BITS-1:0] == rptr[BITS-1:0]);
  assign rdata = mem[rptr[BITS-1:0]];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + (BITS+1)'(1);
      if (pop && !empty)
        rptr <= rptr + (BITS+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[BITS-1:0]] <= wdata;
  end
endmodule

// state | meaning
// IDLE  | sck follows cpol; waits for a queued TX byte
// LOAD  | pops TX byte into the shifter, latches cpol/cpha
// SHIFT | 16 sck edges, one every CLOCK_DIV clks
// STORE | pushes the received byte into RX (or flags overrun)
module spi_master #(
  parameter int CLOCK_DIV          = 4,
  parameter int CLOCK_COUNTER_BITS = 3,
  parameter int FIFO_BITS          = 2,
  parameter int NCS_COUNT          = 2
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 addr,
  input  logic                 nwr,
  input  logic                 nrd,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 sck,
  output logic                 mosi,
  input  logic                 miso,
  output logic [NCS_COUNT-1:0] ncs,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

  localparam logic [CLOCK_COUNTER_BITS-1:0] DIV_LOAD = CLOCK_COUNTER_BITS'(CLOCK_DIV - 1);

  state_t state, state_nxt;

  logic nwr_q, nwr_qq, nrd_q, nrd_qq, rd_addr;
  logic wr_evt, rd_evt;
  logic tx_push, tx_pop, rx_push, rx_pop, ctrl_wr;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0] tx_rdata, rx_rdata;

  logic cpol, cpha, overrun;
  logic [NCS_COUNT-1:0] ncs_r;

  logic [7:0] shreg;
  logic rx_bit, cpol_l, cpha_l, sck_r, mosi_r;
  logic [CLOCK_COUNTER_BITS-1:0] div_cnt;
  logic [4:0] edge_cnt;
  logic sck_edge, last_edge;

  // Strobes are levels; act once per access (write on fall, read pop on release).
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      nwr_q   <= 1'b1;
      nwr_qq  <= 1'b1;
      nrd_q   <= 1'b1;
      nrd_qq  <= 1'b1;
      rd_addr <= 1'b0;
    end else begin
      nwr_q  <= nwr;
      nwr_qq <= nwr_q;
      nrd_q  <= nrd;
      nrd_qq <= nrd_q;
      if (!nrd_q)
        rd_addr <= addr;
    end
  end

  assign wr_evt  = nwr_qq & ~nwr_q;
  assign rd_evt  = ~nrd_qq & nrd_q;
  assign tx_push = wr_evt & ~addr;
  assign ctrl_wr = wr_evt & addr;
  assign rx_pop  = rd_evt & ~rd_addr;

  spi_master_fifo #(.BITS(FIFO_BITS)) u_tx_fifo (
    .clk   (clk),
    .nreset(nreset),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (data_in),
    .rdata (tx_rdata),
    .full  (tx_full),
    .empty (tx_empty)
  );

  spi_master_fifo #(.BITS(FIFO_BITS)) u_rx_fifo (
    .clk   (clk),
    .nreset(nreset),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (shreg),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cpol    <= 1'b0;
      cpha    <= 1'b0;
      overrun <= 1'b0;
      ncs_r   <= '1;
    end else begin
      if (ctrl_wr) begin
        cpol  <= data_in[0];
        cpha  <= data_in[1];
        ncs_r <= data_in[NCS_COUNT+1:2];
        if (data_in[7])
          overrun <= 1'b0;
      end
      if (rx_push && rx_full)
        overrun <= 1'b1;
    end
  end

  assign sck_edge  = (state == SHIFT) && (div_cnt == '0);
  assign last_edge = sck_edge && (edge_cnt == 5'd15);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!tx_empty) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_edge) state_nxt = STORE;
      STORE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_pop  = (state == LOAD);
    rx_push = (state == STORE);
    busy    = (state != IDLE) || !tx_empty;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shreg    <= '0;
      rx_bit   <= 1'b0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      sck_r    <= 1'b0;
      mosi_r   <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      case (state)
        IDLE: sck_r <= cpol;
        LOAD: begin
          shreg    <= tx_rdata;
          cpol_l   <= cpol;
          cpha_l   <= cpha;
          sck_r    <= cpol;
          edge_cnt <= '0;
          div_cnt  <= DIV_LOAD;
          if (!cpha)
            mosi_r <= tx_rdata[7];
        end
        SHIFT: begin
          if (sck_edge) begin
            div_cnt  <= DIV_LOAD;
            sck_r    <= ~sck_r;
            edge_cnt <= edge_cnt + 5'd1;
            // Even edge count = leading edge of the bit cell.
            if (!edge_cnt[0]) begin
              if (cpha_l)
                mosi_r <= shreg[7];
              else
                rx_bit <= miso;
            end else if (cpha_l) begin
              shreg <= {shreg[6:0], miso};
            end else begin
              shreg  <= {shreg[6:0], rx_bit};
              mosi_r <= shreg[6];
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sck  = sck_r;
  assign mosi = mosi_r;
  assign ncs  = ncs_r;

  assign data_out = addr ? {2'b00, cpha, cpol, overrun, busy, rx_empty, tx_full} : rx_rdata;
endmodule
